fifo_rd_ctrl: RTL
=================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-domain controller of the async FIFO; counterpart of the write-side logic fed by sync_r2w.
//  Consumes the write pointer synchronized into rclk and produces the Gray read pointer for sync_r2w.
//  Drives the dual-port RAM read port and presents first-word-fall-through (FWFT) data.
//  Contains a 2-entry output buffer (out reg + skid reg) so it can sustain 1 word/rclk.
// PARAMETERS
//  DATA_WIDTH  8   width of one FIFO word
//  ADDR_WIDTH  4   RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  AE_THRESH   2   almost_empty asserted while rd_count <= AE_THRESH
// PORTS
//  rclk            in   1             read clock
//  rrst_n          in   1             asynchronous active-low reset
//  wptr_gray_sync  in   ADDR_WIDTH+1  write pointer (Gray), already synchronized to rclk
//  rd_en           in   1             consumer pop request
//  mem_rdata       in   DATA_WIDTH    RAM read data, valid the cycle after mem_ren
//  mem_ren         out  1             RAM read strobe (combinational)
//  raddr           out  ADDR_WIDTH    RAM read address = rbin[ADDR_WIDTH-1:0]
//  rptr_gray       out  ADDR_WIDTH+1  registered Gray read pointer, to sync_r2w
//  rdata           out  DATA_WIDTH    head-of-FIFO word, valid while rvalid
//  rvalid          out  1             rdata holds a valid word
//  empty           out  1             = !rvalid
//  almost_empty    out  1             registered, rd_count <= AE_THRESH
//  rd_count        out  ADDR_WIDTH+2  registered words available to consumer
//  underflow       out  1             1-cycle pulse: rd_en while !rvalid
// BEHAVIOUR
//  Reset (async, rrst_n=0): rbin, rptr_gray, inflight, skid_valid, rvalid, rdata, rd_count,
//   underflow = 0; empty = 1; almost_empty = 1. Any in-flight RAM read is discarded.
//  pop = rd_en & rvalid. rd_en while !rvalid: underflow=1 next cycle, no other state change.
//  mem_nonempty = (rptr_gray != wptr_gray_sync) (full-width compare incl. MSB).
//  occ = rvalid + skid_valid + inflight (0..3). Fetch condition:
//   mem_ren = mem_nonempty & ((occ - pop) < 2). Never fetch when occ - pop >= 2.
//  On fetch: rbin <= rbin+1 (mod 2**(ADDR_WIDTH+1)), rptr_gray <= bin2gray(rbin+1), inflight <= 1;
//   else inflight <= 0. RAM slot is released at fetch (rptr advances then, not at pop).
//  Data return (inflight=1, word = mem_rdata):
//   - if !rvalid, or pop & !skid_valid: rdata <= word, rvalid <= 1.
//   - else: skid <= word, skid_valid <= 1 (skid must be empty; otherwise assertion error).
//  Pop without return: if skid_valid, rdata <= skid, skid_valid <= 0; else rvalid <= 0.
//  Pop with return and skid_valid: rdata <= skid, skid <= word (skid_valid stays 1).
//  Latency: wptr_gray_sync changes in cycle t (FIFO was empty) -> mem_ren in t -> rvalid=1 in t+2.
//  Throughput: rd_en held high with data available -> one word per rclk, no bubbles.
//  rd_count = (gray2bin(wptr_gray_sync) - rbin) mod 2**(ADDR_WIDTH+1) + occ, registered (1-cycle lag);
//   maximum DEPTH+2. almost_empty derived from next-state rd_count, registered.
//  Wrap-around: pointers roll over at 2*DEPTH; MSB difference distinguishes wrap, raddr wraps at DEPTH.
//  Simultaneous pop + return + fetch in one cycle is legal and keeps occ constant.
//  wptr_gray_sync is trusted to change by at most one Gray step relationship per write domain; no
//   checking beyond: assertion that (gray2bin(wptr_gray_sync) - rbin) <= DEPTH.
// TESTING
//  Reset: hold rrst_n=0, toggle inputs -> rvalid=0, empty=1, almost_empty=1, rptr_gray=0, mem_ren=0.
//  Single word: wptr_gray_sync 0->1 at cycle t, mem_rdata=8'hA5 at t+1 -> rvalid=1, rdata=A5 at t+2,
//   rptr_gray=1; pop -> empty=1 next cycle, rd_count=0.
//  Burst: preload ptr=16 (DEPTH=16, gray 5'b11000), rd_en held -> 16 words in order, 1/cycle,
//   rptr_gray reaches 5'b11000, no gap after first word.
//  Backpressure: ptr=5 available, rd_en=0 -> exactly 2 fetches (rptr_gray=gray(2)), rd_count=5,
//   mem_ren=0 thereafter; then rd_en=1 -> remaining 3 fetched, 5 words out in order.
//  Underflow: rd_en=1 while empty -> underflow pulse 1 cycle, rbin/rdata unchanged.
//  Wrap + reset mid-op: stream 40 words (pointer wraps past 31->0) with random rd_en, data matches;
//   assert rrst_n=0 with inflight=1 -> all outputs at reset values same cycle, returned word dropped.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read side: fetches from RAM into a 2-deep out/skid buffer with FWFT output.
// Latency: wptr change to rvalid is 2 rclk; sustains 1 word/rclk; no fetch while the buffer plus in-flight read would exceed 2.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH+1:0] rd_count,
    output logic                  underflow
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int CW    = ADDR_WIDTH + 2;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [PW-1:0]         rbin, rbin_nxt, wbin, mem_words;
    logic                  inflight, skid_valid;
    logic [DATA_WIDTH-1:0] skid;
    logic                  pop, mem_nonempty, fetch;
    logic [1:0]            occ, occ_after_pop, occ_nxt;
    logic                  rvalid_nxt, skid_valid_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt, skid_nxt;
    logic [CW-1:0]         count_nxt;

    assign pop           = rd_en & rvalid;
    assign wbin          = gray2bin(wptr_gray_sync);
    assign mem_nonempty  = (rptr_gray != wptr_gray_sync);
    assign occ           = 2'(rvalid) + 2'(skid_valid) + 2'(inflight);
    assign occ_after_pop = occ - 2'(pop);
    // Held off during reset so no read is issued whose data would be discarded anyway.
    assign fetch         = rrst_n & mem_nonempty & (occ_after_pop < 2'd2);
    assign mem_ren       = fetch;
    assign raddr         = rbin[ADDR_WIDTH-1:0];
    assign rbin_nxt      = fetch ? rbin + PW'(1) : rbin;
    assign empty         = ~rvalid;

    always_comb begin
        rvalid_nxt     = rvalid;
        skid_valid_nxt = skid_valid;
        rdata_nxt      = rdata;
        skid_nxt       = skid;
        if (inflight) begin
            if (!rvalid || (pop && !skid_valid)) begin
                rdata_nxt  = mem_rdata;
                rvalid_nxt = 1'b1;
            end else begin
                // Returning word parks in skid; on a pop the old skid word moves up.
                if (pop) rdata_nxt = skid;
                skid_nxt       = mem_rdata;
                skid_valid_nxt = 1'b1;
            end
        end else if (pop) begin
            if (skid_valid) begin
                rdata_nxt      = skid;
                skid_valid_nxt = 1'b0;
            end else begin
                rvalid_nxt = 1'b0;
            end
        end
    end

    assign occ_nxt   = 2'(rvalid_nxt) + 2'(skid_valid_nxt) + 2'(fetch);
    assign mem_words = wbin - rbin_nxt;
    assign count_nxt = CW'(mem_words) + CW'(occ_nxt);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            inflight     <= 1'b0;
            skid_valid   <= 1'b0;
            skid         <= '0;
            rvalid       <= 1'b0;
            rdata        <= '0;
            rd_count     <= '0;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_nxt;
            rptr_gray    <= rbin_nxt ^ (rbin_nxt >> 1);
            inflight     <= fetch;
            skid_valid   <= skid_valid_nxt;
            skid         <= skid_nxt;
            rvalid       <= rvalid_nxt;
            rdata        <= rdata_nxt;
            rd_count     <= count_nxt;
            almost_empty <= (count_nxt <= CW'(AE_THRESH));
            underflow    <= rd_en & ~rvalid;
        end
    end

    skid_free_on_park: assert property (@(posedge rclk) disable iff (!rrst_n)
        (inflight && rvalid && !pop) |-> !skid_valid);

    wptr_in_range: assert property (@(posedge rclk) disable iff (!rrst_n)
        (PW'(wbin - rbin) <= PW'(DEPTH)));
endmodule
